mmio_router: RTL

MMIO_ROUTER -- requirements
Module: mmio_router

---
 rtl/mmio_router_pkg.sv | 9 +
 rtl/mmio_addr_decoder.sv | 24 ++
 rtl/mmio_router.sv | 110 +++++++++++
 3 files changed

// File: rtl/mmio_router_pkg.sv
// eei: shared types and default address map for the MMIO router.
package eei;
    localparam int MAX_DEV = 8;
    localparam logic [31:0] DEF_BASE0 = 32'h1000_0000;
    localparam logic [31:0] DEF_BASE1 = 32'h0200_0000;
    localparam logic [31:0] DEF_MASK0 = 32'hFFFF_F000;
    localparam logic [31:0] DEF_MASK1 = 32'hFFFF_0000;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} mmio_state_t;
endpackage

// File: rtl/mmio_addr_decoder.sv
// mmio_addr_decoder: masked base-address match, lowest matching index wins.
module mmio_addr_decoder import eei::*; #(
    parameter int NUM_DEV = 2,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] DEV_BASE [NUM_DEV] = '{DEF_BASE0, DEF_BASE1},
    parameter logic [ADDR_W-1:0] DEV_MASK [NUM_DEV] = '{DEF_MASK0, DEF_MASK1},
    parameter int IDX_W = NUM_DEV > 1 ? $clog2(NUM_DEV) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan downward so the lowest matching index is the one left standing.
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if ((addr & DEV_MASK[i]) == DEV_BASE[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/mmio_router.sv
// mmio_router: routes single-outstanding core MMIO requests to one of NUM_DEV devices,
// with an error response for unmapped addresses and an optional response timeout.
module mmio_router import eei::*; #(
    parameter int NUM_DEV = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] DEV_BASE [NUM_DEV] = '{DEF_BASE0, DEF_BASE1},
    parameter logic [ADDR_W-1:0] DEV_MASK [NUM_DEV] = '{DEF_MASK0, DEF_MASK1},
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      core_valid,
    output logic                      core_ready,
    input  logic [ADDR_W-1:0]         core_addr,
    input  logic                      core_wen,
    input  logic [DATA_W-1:0]         core_wdata,
    input  logic [DATA_W/8-1:0]       core_wmask,
    output logic                      core_rvalid,
    output logic [DATA_W-1:0]         core_rdata,
    output logic                      core_err,
    output logic [NUM_DEV-1:0]        dev_valid,
    input  logic [NUM_DEV-1:0]        dev_ready,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic                      dev_wen,
    output logic [DATA_W-1:0]         dev_wdata,
    output logic [DATA_W/8-1:0]       dev_wmask,
    input  logic [NUM_DEV-1:0]        dev_rvalid,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata
);
    localparam int IDX_W = NUM_DEV > 1 ? $clog2(NUM_DEV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

    mmio_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wen_q, wen_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W/8-1:0]  wmask_q, wmask_d;
    logic [IDX_W-1:0]     idx_q, idx_d, dec_idx;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dec_hit, rsp, accept, tmo;

    mmio_addr_decoder #(
        .NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W), .DEV_BASE(DEV_BASE), .DEV_MASK(DEV_MASK), .IDX_W(IDX_W)
    ) u_dec (
        .addr(core_addr),
        .hit(dec_hit),
        .idx(dec_idx)
    );

    always_comb begin
        rsp = state_q == WAIT && dev_rvalid[idx_q];
        core_ready = state_q == IDLE || rsp;
        accept = core_valid && core_ready;
        cnt_d = (state_q == ISSUE || state_q == WAIT) ? cnt_q + 1'b1 : cnt_q;
        tmo = TIMEOUT_CYC != 0 && cnt_d == CNT_W'(TIMEOUT_CYC);
        state_d = state_q;
        addr_d = addr_q;
        wen_d = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        idx_d = idx_q;
        case (state_q)
            ISSUE:   state_d = tmo ? ERR : dev_ready[idx_q] ? WAIT : ISSUE;
            WAIT:    state_d = rsp ? IDLE : tmo ? ERR : WAIT;
            ERR:     state_d = IDLE;
            default: state_d = state_q;
        endcase
        // An accept in the response cycle overrides the return to IDLE.
        if (accept) begin
            addr_d = core_addr;
            wen_d = core_wen;
            wdata_d = core_wdata;
            wmask_d = core_wmask;
            idx_d = dec_idx;
            cnt_d = '0;
            state_d = dec_hit ? ISSUE : ERR;
        end
        dev_valid = '0;
        dev_valid[idx_q] = state_q == ISSUE;
        core_rvalid = rsp || state_q == ERR;
        core_err = state_q == ERR;
        core_rdata = rsp ? dev_rdata[int'(idx_q) * DATA_W +: DATA_W] : '0;
    end

    assign dev_addr = addr_q & ~DEV_MASK[idx_q];
    assign dev_wen = wen_q;
    assign dev_wdata = wdata_q;
    assign dev_wmask = wmask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            wen_q <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wen_q <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
